// File: rtl/mem_arb.sv
// Two-port memory arbiter: shares one memory bus between instruction-fetch and data ports.
// Latency: strobe at t, mem strobe at t+1, data and busy clear at t+3 with zero-wait memory.
// Backpressure: one pending request per port; strobes while pending are dropped, not queued.
// Optional: define MEM_ARB_RR_EN for round-robin arbitration (default is data-over-instruction).
module mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction port
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_rstrb,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_rbusy,
    // data port
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    input  logic                  d_rstrb,
    input  logic                  d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_rbusy,
    output logic                  d_wbusy,
    // memory bus
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    output logic                  mem_rstrb,
    output logic                  mem_wstrb,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_rbusy,
    input  logic                  mem_wbusy
);

    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t              state_q;

    // Per-port pending registers.
    logic                i_vld_q;
    logic [ADDR_W-1:0]   i_addr_q;
    logic                d_vld_q;
    logic                d_wr_q;
    logic [ADDR_W-1:0]   d_addr_q;
    logic [DATA_W-1:0]   d_wdata_q;
    logic [MASK_W-1:0]   d_wmask_q;

    // Last issued request, held on the bus outside the issue cycle.
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic [MASK_W-1:0]   mem_wmask_q;

    logic [DATA_W-1:0]   i_rdata_q;
    logic [DATA_W-1:0]   d_rdata_q;

    // Set for the cycle after a completion: the FSM is back in IDLE but the
    // next grant waits one cycle so a finished access never overlaps the next issue.
    logic                turn_q;

`ifdef MEM_ARB_RR_EN
    // 1 = data port received the most recent grant.
    logic                last_d_q;
`endif

    logic                pick_d;
    logic                issue;
    logic                win_wr;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [MASK_W-1:0]   win_wmask;
    logic                i_done;
    logic                d_done;
    logic                i_cap;
    logic                d_cap;

    // Arbitration and issue decision, all from registered state.
    always_comb begin
`ifdef MEM_ARB_RR_EN
        pick_d    = d_vld_q && (!i_vld_q || !last_d_q);
`else
        pick_d    = d_vld_q;
`endif
        issue     = !rst && (state_q == IDLE) && !turn_q && (i_vld_q || d_vld_q);
        win_wr    = pick_d && d_wr_q;
        win_addr  = pick_d ? d_addr_q  : i_addr_q;
        win_wdata = pick_d ? d_wdata_q : '0;
        win_wmask = pick_d ? d_wmask_q : '0;
    end

    // Completion and capture qualifiers.
    always_comb begin
        i_done = (state_q == GRANT_I) && !mem_rbusy;
        d_done = (state_q == GRANT_D) && (d_wr_q ? !mem_wbusy : !mem_rbusy);
        i_cap  = !i_vld_q && i_rstrb;
        d_cap  = !d_vld_q && (d_rstrb || d_wstrb);
    end

    // Pending-request capture: a port accepts a new strobe only when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_addr_q  <= '0;
            d_addr_q  <= '0;
            d_wr_q    <= 1'b0;
            d_wdata_q <= '0;
            d_wmask_q <= '0;
        end else begin
            if (i_cap) begin
                i_addr_q <= i_addr;
            end
            if (d_cap) begin
                // A write wins over a simultaneous read; the read is dropped.
                d_addr_q  <= d_addr;
                d_wr_q    <= d_wstrb;
                d_wdata_q <= d_wstrb ? d_wdata : '0;
                d_wmask_q <= d_wstrb ? d_wmask : '0;
            end
        end
    end

    // Grant FSM: issues from IDLE, waits for memory, returns data and frees the port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_vld_q     <= 1'b0;
            d_vld_q     <= 1'b0;
            turn_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            turn_q <= i_done || d_done;
            if (i_cap) begin
                i_vld_q <= 1'b1;
            end
            if (d_cap) begin
                d_vld_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        mem_addr_q  <= win_addr;
                        mem_wdata_q <= win_wdata;
                        mem_wmask_q <= win_wmask;
                        state_q     <= pick_d ? GRANT_D : GRANT_I;
                    end
                end
                GRANT_I: begin
                    if (i_done) begin
                        i_rdata_q <= mem_rdata;
                        i_vld_q   <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                GRANT_D: begin
                    if (d_done) begin
                        if (!d_wr_q) begin
                            d_rdata_q <= mem_rdata;
                        end
                        d_vld_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_RR_EN
    // Remember which port was granted last so the other wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_q <= 1'b0;
        end else if (issue) begin
            last_d_q <= pick_d;
        end
    end
`endif

    // Output drive: the bus follows the winner in the issue cycle and holds it afterwards.
    always_comb begin
        mem_rstrb = issue && !win_wr;
        mem_wstrb = issue && win_wr;
        mem_addr  = issue ? win_addr  : mem_addr_q;
        mem_wdata = issue ? win_wdata : mem_wdata_q;
        mem_wmask = issue ? win_wmask : mem_wmask_q;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
        i_rbusy   = i_vld_q;
        d_rbusy   = d_vld_q && !d_wr_q;
        d_wbusy   = d_vld_q && d_wr_q;
    end

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: checks reset, fetch, waited store, contention,
// held strobe, read/write collision and reset during a grant.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic        i_rstrb;
    logic [31:0] i_rdata;
    logic        i_rbusy;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic        d_rstrb;
    logic        d_wstrb;
    logic [31:0] d_rdata;
    logic        d_rbusy;
    logic        d_wbusy;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rstrb;
    logic        mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        mem_wbusy;

    int tests = 0;
    int fails = 0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_addr    (i_addr),
        .i_rstrb   (i_rstrb),
        .i_rdata   (i_rdata),
        .i_rbusy   (i_rbusy),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wmask   (d_wmask),
        .d_rstrb   (d_rstrb),
        .d_wstrb   (d_wstrb),
        .d_rdata   (d_rdata),
        .d_rbusy   (d_rbusy),
        .d_wbusy   (d_wbusy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int pulses;
    int bad_gap;
    int last_pulse;

    initial begin
        rst = 1'b1;
        i_addr = '0; i_rstrb = 1'b0;
        d_addr = '0; d_wdata = '0; d_wmask = '0; d_rstrb = 1'b0; d_wstrb = 1'b0;
        mem_rdata = '0; mem_rbusy = 1'b0; mem_wbusy = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_i_rbusy",  {31'd0, i_rbusy},   32'd0);
        chk("rst_d_busy",   {30'd0, d_rbusy, d_wbusy}, 32'd0);
        chk("rst_strobes",  {30'd0, mem_rstrb, mem_wstrb}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_i_rdata",  i_rdata,  32'd0);
        rst = 1'b0;
        tick();

        // Single fetch, zero-wait memory
        i_rstrb = 1'b1; i_addr = 32'h100; mem_rdata = 32'h0050_0093;
        tick();                                   // t+1
        i_rstrb = 1'b0;
        chk("fetch_rstrb",  {31'd0, mem_rstrb}, 32'd1);
        chk("fetch_wstrb",  {31'd0, mem_wstrb}, 32'd0);
        chk("fetch_addr",   mem_addr, 32'h100);
        chk("fetch_busy1",  {31'd0, i_rbusy}, 32'd1);
        tick();                                   // t+2
        chk("fetch_rstrb2", {31'd0, mem_rstrb}, 32'd0);
        chk("fetch_busy2",  {31'd0, i_rbusy}, 32'd1);
        tick();                                   // t+3
        chk("fetch_rdata",  i_rdata, 32'h0050_0093);
        chk("fetch_busy3",  {31'd0, i_rbusy}, 32'd0);
        tick();

        // Byte store with two memory wait cycles
        d_wstrb = 1'b1; d_addr = 32'h2003; d_wdata = 32'hAAAA_AAAA; d_wmask = 4'b1000;
        tick();                                   // t+1
        d_wstrb = 1'b0; d_wdata = '0; d_wmask = '0; d_addr = '0;
        chk("st_wstrb",  {31'd0, mem_wstrb}, 32'd1);
        chk("st_rstrb",  {31'd0, mem_rstrb}, 32'd0);
        chk("st_addr",   mem_addr, 32'h2003);
        chk("st_wdata",  mem_wdata, 32'hAAAA_AAAA);
        chk("st_wmask",  {28'd0, mem_wmask}, 32'h8);
        chk("st_wbusy1", {31'd0, d_wbusy}, 32'd1);
        mem_wbusy = 1'b1;
        tick();                                   // t+2
        chk("st_wstrb2", {31'd0, mem_wstrb}, 32'd0);
        chk("st_hold",   mem_addr, 32'h2003);
        tick();                                   // t+3
        chk("st_wbusy3", {31'd0, d_wbusy}, 32'd1);
        tick();                                   // t+4
        mem_wbusy = 1'b0;
        chk("st_wbusy4", {31'd0, d_wbusy}, 32'd1);
        tick();                                   // t+5
        chk("st_wbusy5", {31'd0, d_wbusy}, 32'd0);
        chk("st_rdata",  d_rdata, 32'd0);
        tick();

        // Simultaneous fetch and load (fixed: data first; round-robin: data was last, so fetch first)
        i_rstrb = 1'b1; i_addr = 32'h200; d_rstrb = 1'b1; d_addr = 32'h300;
        tick();                                   // t+1
        i_rstrb = 1'b0; d_rstrb = 1'b0;
        mem_rdata = 32'hDDDD_0000;
        chk("con_first_addr",  mem_addr, RR ? 32'h200 : 32'h300);
        chk("con_first_rstrb", {31'd0, mem_rstrb}, 32'd1);
        tick();                                   // t+2
        tick();                                   // t+3
        mem_rdata = 32'h1A1A_1A1A;
        chk("con_first_done",  {31'd0, (RR ? i_rbusy : d_rbusy)}, 32'd0);
        chk("con_first_data",  RR ? i_rdata : d_rdata, 32'hDDDD_0000);
        chk("con_loser_busy",  {31'd0, (RR ? d_rbusy : i_rbusy)}, 32'd1);
        chk("con_gap_rstrb",   {31'd0, mem_rstrb}, 32'd0);
        tick();                                   // t+4
        chk("con_second_rstrb", {31'd0, mem_rstrb}, 32'd1);
        chk("con_second_addr",  mem_addr, RR ? 32'h300 : 32'h200);
        tick();                                   // t+5
        chk("con_second_busy",  {31'd0, (RR ? d_rbusy : i_rbusy)}, 32'd1);
        tick();                                   // t+6
        chk("con_second_done",  {31'd0, (RR ? d_rbusy : i_rbusy)}, 32'd0);
        chk("con_second_data",  RR ? d_rdata : i_rdata, 32'h1A1A_1A1A);
        tick(); tick();

        // Held i_rstrb for 20 cycles: one memory read every 3 cycles
        i_rstrb = 1'b1; i_addr = 32'h400;
        pulses = 0; bad_gap = 0; last_pulse = -1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 20) i_rstrb = 1'b0;
            if (mem_rstrb) begin
                if (last_pulse >= 0 && (k - last_pulse) != 3) bad_gap++;
                last_pulse = k;
                pulses++;
            end
        end
        chk("held_pulses", pulses, 32'd7);
        chk("held_gaps",   bad_gap, 32'd0);
        chk("held_first",  {31'd0, mem_wstrb}, 32'd0);
        tick(); tick();

        // Read and write strobes together: write wins, read dropped
        d_rstrb = 1'b1; d_wstrb = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678; d_wmask = 4'hF;
        tick();                                   // t+1
        d_rstrb = 1'b0; d_wstrb = 1'b0;
        chk("rw_wstrb",  {31'd0, mem_wstrb}, 32'd1);
        chk("rw_rstrb",  {31'd0, mem_rstrb}, 32'd0);
        chk("rw_rbusy",  {31'd0, d_rbusy}, 32'd0);
        chk("rw_wbusy",  {31'd0, d_wbusy}, 32'd1);
        chk("rw_wdata",  mem_wdata, 32'h1234_5678);
        tick();                                   // t+2
        chk("rw_rstrb2", {31'd0, mem_rstrb}, 32'd0);
        tick();                                   // t+3
        chk("rw_done",   {30'd0, d_rbusy, d_wbusy}, 32'd0);
        tick(); tick();

        // Reset while a data read waits on the memory
        d_rstrb = 1'b1; d_addr = 32'h80; mem_rdata = 32'hBAD0_BAD0;
        tick();                                   // t+1
        d_rstrb = 1'b0;
        chk("rg_rstrb", {31'd0, mem_rstrb}, 32'd1);
        mem_rbusy = 1'b1;
        tick();                                   // t+2
        chk("rg_wait",  {31'd0, d_rbusy}, 32'd1);
        rst = 1'b1;
        tick();                                   // t+3
        rst = 1'b0; mem_rbusy = 1'b0;
        chk("rg_busy",    {29'd0, i_rbusy, d_rbusy, d_wbusy}, 32'd0);
        chk("rg_strobes", {30'd0, mem_rstrb, mem_wstrb}, 32'd0);
        chk("rg_d_rdata", d_rdata, 32'd0);
        chk("rg_i_rdata", i_rdata, 32'd0);
        tick();                                   // t+4
        chk("rg_after",   {30'd0, mem_rstrb, d_rbusy}, 32'd0);
        chk("rg_data2",   d_rdata, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
